// File: rtl/letter_arb.sv
// Round-robin arbiter feeding one word combiner from NUM_SRC letter streams, granting whole words only.
// Latency: an accepted letter appears on com_letter/com_data_in one cycle later; ARB and CLOSE cost one cycle each.
// Backpressure: only the granted source sees src_ready (in PASS); the combiner side never stalls.
module letter_arb #(
    parameter int                     NUM_SRC      = 4,
    parameter int                     LETTER_SIZE  = 8,
    parameter int                     MAX_LETTERS  = 16,
    parameter logic [LETTER_SIZE-1:0] DELIM        = '0,
    parameter int                     IDLE_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*LETTER_SIZE-1:0] src_letter,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic                           com_data_in,
    output logic [LETTER_SIZE-1:0]         com_letter,
    output logic [$clog2(NUM_SRC)-1:0]     grant_id,
    output logic                           busy
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int LW = $clog2(MAX_LETTERS + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {ARB = 2'd0, PASS = 2'd1, CLOSE = 2'd2} state_t;

    state_t                 state, state_nxt;
    logic [GW-1:0]          grant_nxt;
    logic [GW-1:0]          rr_ptr, rr_nxt;
    logic [LW-1:0]          let_cnt, let_nxt;
    logic [IW-1:0]          idle_cnt, idle_nxt;
    logic                   out_vld_nxt;
    logic [LETTER_SIZE-1:0] out_let_nxt;

    logic                   cur_valid;
    logic [LETTER_SIZE-1:0] cur_letter;
    logic                   accept;
    logic                   found;
    logic [GW-1:0]          pick_idx;

    // Select the granted source's valid and letter.
    always_comb begin
        cur_valid  = 1'b0;
        cur_letter = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (GW'(k) == grant_id) begin
                cur_valid  = src_valid[k];
                cur_letter = src_letter[k*LETTER_SIZE +: LETTER_SIZE];
            end
        end
    end

    // Ready goes only to the granted source and only while passing letters; it depends on registers alone.
    always_comb begin
        src_ready = '0;
        if (state == PASS) begin
            src_ready[grant_id] = 1'b1;
        end
    end

    assign accept = (state == PASS) && cur_valid;
    assign busy   = (state != ARB);

    // Find the first requesting source at or after rr_ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!found && src_valid[idx]) begin
                found    = 1'b1;
                pick_idx = GW'(idx);
            end
        end
    end

    // Next-state logic and the values to register on the combiner side.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        rr_nxt      = rr_ptr;
        let_nxt     = let_cnt;
        idle_nxt    = idle_cnt;
        out_vld_nxt = 1'b0;
        out_let_nxt = com_letter;
        case (state)
            ARB: begin
                if (found) begin
                    grant_nxt = pick_idx;
                    rr_nxt    = (int'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + GW'(1);
                    let_nxt   = '0;
                    idle_nxt  = '0;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    out_vld_nxt = 1'b1;
                    out_let_nxt = cur_letter;
                    idle_nxt    = '0;
                    if (cur_letter == DELIM) begin
                        state_nxt = ARB;
                    end else begin
                        let_nxt = let_cnt + LW'(1);
                        if (let_cnt + LW'(1) == LW'(MAX_LETTERS)) begin
                            state_nxt = CLOSE;
                        end
                    end
                end else begin
                    idle_nxt = idle_cnt + IW'(1);
                    // A stalled source with an open word gets it terminated; an empty word needs nothing.
                    if (idle_cnt + IW'(1) == IW'(IDLE_TIMEOUT)) begin
                        state_nxt = (let_cnt != '0) ? CLOSE : ARB;
                    end
                end
            end
            CLOSE: begin
                out_vld_nxt = 1'b1;
                out_let_nxt = DELIM;
                state_nxt   = ARB;
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // State, arbitration bookkeeping and registered combiner outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB;
            grant_id    <= '0;
            rr_ptr      <= '0;
            let_cnt     <= '0;
            idle_cnt    <= '0;
            com_data_in <= 1'b0;
            com_letter  <= '0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            rr_ptr      <= rr_nxt;
            let_cnt     <= let_nxt;
            idle_cnt    <= idle_nxt;
            com_data_in <= out_vld_nxt;
            com_letter  <= out_let_nxt;
        end
    end
endmodule

// File: tb/tb_letter_arb.sv
// Bench for letter_arb: per-source letter queues drive the inputs, expected combiner letters sit in a scoreboard.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Every comparison goes through chk.
module tb_letter_arb;
    localparam int N  = 4;
    localparam int LS = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*LS-1:0] src_letter = '0;
    logic [N-1:0]    src_ready;
    logic            com_data_in;
    logic [LS-1:0]   com_letter;
    logic [1:0]      grant_id;
    logic            busy;

    letter_arb #(.NUM_SRC(N), .LETTER_SIZE(LS), .MAX_LETTERS(16), .DELIM(8'h00), .IDLE_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_letter(src_letter), .src_ready(src_ready),
        .com_data_in(com_data_in), .com_letter(com_letter), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ltr;
        logic [1:0] gid;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] sq[N][$];
    logic [N-1:0] pend = '0;
    bit         drv_en = 1'b1;
    int         tests = 0, fails = 0;
    int         pulse_cnt = 0, close_cnt = 0, cyc = 0;
    int         pcyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ex(input logic [7:0] l, input logic [1:0] g);
        expq.push_back('{ltr: l, gid: g});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) sq[i].delete();
        expq.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n;
        n = 0;
        while (expq.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(tag, expq.size(), 0);
    endtask

    // Source model: hold each queued letter until it is seen accepted, then move to the next.
    always @(negedge clk) begin
        if (!rst) begin
            pend      = '0;
            src_valid = '0;
        end else if (drv_en) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (sq[i].size() > 0) begin
                    src_valid[i] = 1'b1;
                    src_letter[i*LS +: LS] = sq[i][0];
                end else begin
                    src_valid[i] = 1'b0;
                end
                pend[i] = src_valid[i] & src_ready[i];
            end
        end
    end

    // Combiner-side monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst && com_data_in) begin
            pulse_cnt++;
            pcyc.push_back(cyc);
            if (expq.size() == 0) begin
                chk("unexpected letter", {24'h0, com_letter}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("letter", {24'h0, com_letter}, {24'h0, e.ltr});
                chk("grant", {30'h0, grant_id}, {30'h0, e.gid});
            end
        end
        if (rst && busy && src_ready == '0) close_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p0, b, n;

        // Reset state
        #1;
        chk("rst com_data_in", {31'h0, com_data_in}, 0);
        chk("rst com_letter", {24'h0, com_letter}, 0);
        chk("rst grant_id", {30'h0, grant_id}, 0);
        chk("rst busy", {31'h0, busy}, 0);
        chk("rst src_ready", {28'h0, src_ready}, 0);

        // 1: single source, back-to-back word
        do_reset();
        @(posedge clk); #1;
        c0 = cyc;
        p0 = pulse_cnt;
        sq[1] = '{8'h61, 8'h62, 8'h63, 8'h00};
        ex(8'h61, 1); ex(8'h62, 1); ex(8'h63, 1); ex(8'h00, 1);
        wait_drain("t1 drain", 50);
        chk("t1 pulses", pulse_cnt - p0, 4);
        chk("t1 last cycle", pcyc[pcyc.size()-1] - c0, 6);
        chk("t1 first cycle", pcyc[pcyc.size()-4] - c0, 3);
        chk("t1 busy", {31'h0, busy}, 0);

        // 2: two sources, whole words, pointer wraps
        do_reset();
        @(posedge clk); #1;
        sq[0] = '{8'h11, 8'h12, 8'h00, 8'h13, 8'h14, 8'h00};
        sq[2] = '{8'h21, 8'h22, 8'h00};
        ex(8'h11, 0); ex(8'h12, 0); ex(8'h00, 0);
        ex(8'h21, 2); ex(8'h22, 2); ex(8'h00, 2);
        ex(8'h13, 0); ex(8'h14, 0); ex(8'h00, 0);
        wait_drain("t2 drain", 100);

        // 3: word-length split, then timeout close of the remainder
        do_reset();
        @(posedge clk); #1;
        close_cnt = 0;
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) sq[3].push_back(8'h30 + 8'(i));
        for (int i = 0; i < 16; i++) ex(8'h30 + 8'(i), 3);
        ex(8'h00, 3);
        for (int i = 16; i < 20; i++) ex(8'h30 + 8'(i), 3);
        ex(8'h00, 3);
        n = 0;
        while (expq.size() > 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("t3 pulses before timeout", pulse_cnt - p0, 21);
        chk("t3 close count", close_cnt, 1);
        wait_drain("t3 drain", 150);
        chk("t3 close count after timeout", close_cnt, 2);

        // 4: stalled source forced closed, waiting source served next
        do_reset();
        @(posedge clk); #1;
        b = pcyc.size();
        sq[0] = '{8'h01, 8'h02, 8'h03};
        ex(8'h01, 0); ex(8'h02, 0); ex(8'h03, 0); ex(8'h00, 0);
        ex(8'h51, 3); ex(8'h00, 3);
        n = 0;
        while (!(busy && grant_id == 2'd0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4 src0 granted", {31'h0, busy}, 1);
        @(posedge clk); #1;
        sq[3] = '{8'h51, 8'h00};
        wait_drain("t4 drain", 200);
        chk("t4 timeout gap", pcyc[b+3] - pcyc[b+2], 65);

        // 4b: granted source withdraws before any letter -> release without delimiter
        @(posedge clk); #1;
        drv_en = 1'b0;
        @(negedge clk);
        src_valid = 4'b0001;
        src_letter[7:0] = 8'h77;
        @(negedge clk);
        chk("t4b busy", {31'h0, busy}, 1);
        src_valid = '0;
        p0 = pulse_cnt;
        repeat (100) @(negedge clk);
        chk("t4b no pulse", pulse_cnt - p0, 0);
        chk("t4b released", {31'h0, busy}, 0);
        chk("t4b grant", {30'h0, grant_id}, 0);
        @(posedge clk); #1;
        drv_en = 1'b1;

        // 5: asynchronous reset mid-word
        do_reset();
        @(posedge clk); #1;
        p0 = pulse_cnt;
        sq[1] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h00};
        for (int i = 0; i < 8; i++) ex(8'h81 + 8'(i), 1);
        ex(8'h00, 1);
        n = 0;
        while (pulse_cnt - p0 < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5 mid-word", {31'h0, busy}, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5 com_data_in", {31'h0, com_data_in}, 0);
        chk("t5 src_ready", {28'h0, src_ready}, 0);
        chk("t5 busy", {31'h0, busy}, 0);
        for (int i = 0; i < N; i++) sq[i].delete();
        expq.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        sq[2] = '{8'h91, 8'h00};
        sq[0] = '{8'h92, 8'h00};
        ex(8'h92, 0); ex(8'h00, 0); ex(8'h91, 2); ex(8'h00, 2);
        wait_drain("t5 drain", 50);

        // 6: delimiter as the first letter
        do_reset();
        @(posedge clk); #1;
        sq[2] = '{8'h00};
        sq[3] = '{8'h61, 8'h00};
        ex(8'h00, 2); ex(8'h61, 3); ex(8'h00, 3);
        wait_drain("t6 drain", 50);
        chk("t6 busy", {31'h0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
